// File: rtl/vga_sync_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_sync_checker_if
// Brief    : Video bus seen by the sync checker: pixel strobe, active-low
//            syncs and 3-bit-per-channel colour.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_sync_checker_if;
   logic       pix_en;
   logic       hsync;
   logic       vsync;
   logic [2:0] red;
   logic [2:0] green;
   logic [2:0] blue;

   // Video source side
   modport master (output pix_en, hsync, vsync, red, green, blue);
   // Checker side
   modport slave  (input  pix_en, hsync, vsync, red, green, blue);
endinterface
`default_nettype wire

// File: rtl/vga_sync_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_sync_checker
// Brief    : Measures VGA line/frame/pulse lengths and blanking colour on each
//            pixel strobe, locks onto conforming timing, counts good frames
//            and logs the highest-priority error seen while locked.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_checker #(
   parameter int HPIXELS = 800,
   parameter int VLINES  = 521,
   parameter int HPULSE  = 96,
   parameter int HBP     = 144,
   parameter int HFP     = 784,
   parameter int VPULSE  = 2,
   parameter int VBP     = 31,
   parameter int VFP     = 511
) (
   input  logic               clk,
   input  logic               clr,
   vga_sync_checker_if.slave  vid,
   output logic               locked,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [7:0]         err_count,
   output logic [2:0]         err_code
);

   localparam logic [1:0]  c_st_search = 2'd0;
   localparam logic [1:0]  c_st_align  = 2'd1;
   localparam logic [1:0]  c_st_locked = 2'd2;

   localparam logic [2:0]  c_err_none   = 3'd0;
   localparam logic [2:0]  c_err_vlen   = 3'd1;
   localparam logic [2:0]  c_err_vpulse = 3'd2;
   localparam logic [2:0]  c_err_hlen   = 3'd3;
   localparam logic [2:0]  c_err_hpulse = 3'd4;
   localparam logic [2:0]  c_err_blank  = 3'd5;

   // Length checks compare count+1 one bit wider so a saturated 1023 never aliases
   localparam logic [10:0] c_hpixels = 11'(HPIXELS);
   localparam logic [10:0] c_hpulse  = 11'(HPULSE);
   localparam logic [10:0] c_vlines  = 11'(VLINES);
   localparam logic [10:0] c_vpulse  = 11'(VPULSE);
   localparam logic [9:0]  c_hbp     = 10'(HBP);
   localparam logic [9:0]  c_hfp     = 10'(HFP);
   localparam logic [9:0]  c_vbp     = 10'(VBP);
   localparam logic [9:0]  c_vfp     = 10'(VFP);

   logic        r_hs_prev;
   logic        r_vs_prev;
   logic [9:0]  r_hcount;
   logic [9:0]  r_vcount;
   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic        r_frame_done;
   logic [15:0] r_frame_count;
   logic [7:0]  r_err_count;
   logic [2:0]  r_err_code;

   logic        w_hs_fall;
   logic        w_hs_rise;
   logic        w_vs_fall;
   logic        w_vs_rise;
   logic [10:0] w_hcount_inc;
   logic [10:0] w_vcount_inc;
   logic [9:0]  w_hcount_next;
   logic [9:0]  w_vcount_next;
   logic        w_in_active;
   logic        w_rgb_any;
   logic        w_flag_vlen;
   logic        w_flag_vpulse;
   logic        w_flag_hlen;
   logic        w_flag_hpulse;
   logic        w_flag_blank;
   logic [2:0]  w_flag_code;
   logic        w_any_flag;
   logic        w_log_err;
   logic        w_frame_ok;

   // Edges are only meaningful on a pixel sample, so the strobe is folded in here
   assign w_hs_fall = vid.pix_en &  r_hs_prev & ~vid.hsync;
   assign w_hs_rise = vid.pix_en & ~r_hs_prev &  vid.hsync;
   assign w_vs_fall = vid.pix_en &  r_vs_prev & ~vid.vsync;
   assign w_vs_rise = vid.pix_en & ~r_vs_prev &  vid.vsync;

   assign w_hcount_inc  = {1'b0, r_hcount} + 11'd1;
   assign w_vcount_inc  = {1'b0, r_vcount} + 11'd1;
   assign w_hcount_next = w_hs_fall ? 10'd0 : ((&r_hcount) ? r_hcount : w_hcount_inc[9:0]);

   // Line counter: vsync fall restarts the frame and wins over the line step
   always_comb begin
      w_vcount_next = r_vcount;
      if (w_vs_fall) begin
         w_vcount_next = 10'd0;
      end else if (w_hs_fall && !(&r_vcount)) begin
         w_vcount_next = w_vcount_inc[9:0];
      end
   end

   // Blanking is judged on the position this sample is being counted as
   assign w_in_active = (w_hcount_next >= c_hbp) && (w_hcount_next < c_hfp) &&
                        (w_vcount_next >= c_vbp) && (w_vcount_next < c_vfp);
   assign w_rgb_any   = |{vid.red, vid.green, vid.blue};

   assign w_flag_vlen   = w_vs_fall && (w_vcount_inc != c_vlines);
   assign w_flag_vpulse = w_vs_rise && (w_vcount_inc != c_vpulse);
   assign w_flag_hlen   = w_hs_fall && (w_hcount_inc != c_hpixels);
   assign w_flag_hpulse = w_hs_rise && (w_hcount_inc != c_hpulse);
   assign w_flag_blank  = vid.pix_en && w_rgb_any && !w_in_active;

   // Priority encode simultaneous flags, frame-level errors first
   always_comb begin
      w_flag_code = c_err_none;
      if (w_flag_vlen) begin
         w_flag_code = c_err_vlen;
      end else if (w_flag_vpulse) begin
         w_flag_code = c_err_vpulse;
      end else if (w_flag_hlen) begin
         w_flag_code = c_err_hlen;
      end else if (w_flag_hpulse) begin
         w_flag_code = c_err_hpulse;
      end else if (w_flag_blank) begin
         w_flag_code = c_err_blank;
      end
   end

   assign w_any_flag = (w_flag_code != c_err_none);

   // Lock state register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= c_st_search;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Lock next-state: a full clean frame in ALIGN is needed before LOCKED
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_search: begin
            if (w_vs_fall) begin
               w_state_next = c_st_align;
            end
         end
         c_st_align: begin
            if (w_any_flag) begin
               w_state_next = c_st_search;
            end else if (w_vs_fall) begin
               w_state_next = c_st_locked;
            end
         end
         c_st_locked: begin
            if (w_any_flag) begin
               w_state_next = c_st_search;
            end
         end
         default: w_state_next = c_st_search;
      endcase
   end

   // Lock outputs: errors are only logged, and frames only counted, while locked
   always_comb begin
      locked     = (r_state == c_st_locked);
      w_log_err  = (r_state == c_st_locked) && w_any_flag;
      w_frame_ok = (r_state == c_st_locked) && w_vs_fall && !w_any_flag;
   end

   // Sync history and position counters advance only on pixel samples
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_hs_prev <= 1'b1;
         r_vs_prev <= 1'b1;
         r_hcount  <= 10'd0;
         r_vcount  <= 10'd0;
      end else if (vid.pix_en) begin
         r_hs_prev <= vid.hsync;
         r_vs_prev <= vid.vsync;
         r_hcount  <= w_hcount_next;
         r_vcount  <= w_vcount_next;
      end
   end

   // Status: one-clk frame pulse, wrapping frame count, saturating error log
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_frame_done  <= 1'b0;
         r_frame_count <= 16'd0;
         r_err_count   <= 8'd0;
         r_err_code    <= c_err_none;
      end else begin
         r_frame_done <= w_frame_ok;
         if (w_frame_ok) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_log_err) begin
            r_err_code <= w_flag_code;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
      end
   end

   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign err_count   = r_err_count;
   assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_checker
// Brief    : Scripted bench for vga_sync_checker on a shrunken 8x6 raster;
//            expected frame/error events are queued as stimulus is driven and
//            matched when the checker reports them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_checker;

   localparam int c_hp  = 8;
   localparam int c_hpw = 2;
   localparam int c_hbp = 3;
   localparam int c_hfp = 7;
   localparam int c_vl  = 6;
   localparam int c_vpw = 2;
   localparam int c_vbp = 3;
   localparam int c_vfp = 5;

   typedef struct {
      bit          is_err;
      logic [2:0]  code;
      logic [7:0]  errs;
      logic [15:0] frames;
   } ev_t;

   logic        tb_dclk = 1'b0;
   logic        clr;
   logic        locked;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [7:0]  err_count;
   logic [2:0]  err_code;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   pix_div  = 4;
   int   exp_frames = 0;
   int   exp_errs   = 0;
   ev_t  sb_q[$];
   ev_t  mon_ev;
   logic prev_locked = 1'b0;

   vga_sync_checker_if vif ();

   vga_sync_checker #(
      .HPIXELS (c_hp),
      .VLINES  (c_vl),
      .HPULSE  (c_hpw),
      .HBP     (c_hbp),
      .HFP     (c_hfp),
      .VPULSE  (c_vpw),
      .VBP     (c_vbp),
      .VFP     (c_vfp)
   ) dut (
      .clk         (tb_dclk),
      .clr         (clr),
      .vid         (vif),
      .locked      (locked),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .err_count   (err_count),
      .err_code    (err_code)
   );

   always #5 tb_dclk = ~tb_dclk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      ev_t e;
      exp_frames++;
      e.is_err = 1'b0;
      e.code   = 3'd0;
      e.errs   = 8'd0;
      e.frames = 16'(exp_frames);
      sb_q.push_back(e);
   endtask

   task automatic push_err(input logic [2:0] code);
      ev_t e;
      if (exp_errs < 255) exp_errs++;
      e.is_err = 1'b1;
      e.code   = code;
      e.errs   = 8'(exp_errs);
      e.frames = 16'd0;
      sb_q.push_back(e);
   endtask

   // One pixel: present the values with the strobe, then idle pix_div-1 clocks
   task automatic drive_pix(input logic hs, input logic vs,
                            input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
      vif.hsync  = hs;
      vif.vsync  = vs;
      vif.red    = r;
      vif.green  = g;
      vif.blue   = b;
      vif.pix_en = 1'b1;
      @(posedge tb_dclk);
      #1;
      vif.pix_en = 1'b0;
      for (int k = 1; k < pix_div; k++) begin
         @(posedge tb_dclk);
         #1;
      end
   endtask

   // Raster generator with knobs for one bad line, vsync width and a stray pixel
   task automatic drive_frame(input int nlines, input int vpl, input int bad_line,
                              input int bad_len, input int bad_hpw,
                              input int rgb_line, input int rgb_pix);
      for (int l = 0; l < nlines; l++) begin
         int len;
         int hpw;
         len = (l == bad_line) ? bad_len : c_hp;
         hpw = (l == bad_line) ? bad_hpw : c_hpw;
         for (int p = 0; p < len; p++) begin
            logic [2:0] r;
            logic [2:0] g;
            logic [2:0] b;
            bit act;
            act = (l >= c_vbp) && (l < c_vfp) && (p >= c_hbp) && (p < c_hfp);
            r = act ? 3'(p + 1) : 3'b000;
            g = act ? 3'b010    : 3'b000;
            b = act ? 3'(l)     : 3'b000;
            if (l == rgb_line && p == rgb_pix) r = 3'b001;
            drive_pix(p >= hpw, l >= vpl, r, g, b);
         end
      end
   endtask

   task automatic good_frame();
      drive_frame(c_vl, c_vpw, -1, c_hp, c_hpw, -1, -1);
   endtask

   // Event monitor: a frame pulse or a loss of lock must match the queue head
   always @(negedge tb_dclk) begin
      if (!clr && (frame_done || (prev_locked && !locked))) begin
         check_val("sb_has_exp", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_ev = sb_q.pop_front();
            check_val("ev_kind", 32'(!frame_done), 32'(mon_ev.is_err));
            if (mon_ev.is_err) begin
               check_val("ev_err_code", 32'(err_code), 32'(mon_ev.code));
               check_val("ev_err_count", 32'(err_count), 32'(mon_ev.errs));
            end else begin
               check_val("ev_frame_count", 32'(frame_count), 32'(mon_ev.frames));
            end
         end
      end
      prev_locked <= clr ? 1'b0 : locked;
   end

   initial begin
      vif.pix_en = 1'b0;
      vif.hsync  = 1'b1;
      vif.vsync  = 1'b1;
      vif.red    = 3'b000;
      vif.green  = 3'b000;
      vif.blue   = 3'b000;
      clr        = 1'b1;
      repeat (3) @(posedge tb_dclk);
      #1;
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_frame_done", 32'(frame_done), 32'd0);
      check_val("rst_frame_count", 32'(frame_count), 32'd0);
      check_val("rst_err_count", 32'(err_count), 32'd0);
      check_val("rst_err_code", 32'(err_code), 32'd0);
      clr = 1'b0;

      // Ideal timing: lock on second vsync fall, one good frame on the third
      good_frame();
      check_val("c1_align_unlocked", 32'(locked), 32'd0);
      good_frame();
      check_val("c1_locked", 32'(locked), 32'd1);
      push_frame();
      good_frame();
      check_val("c1_frame_count", 32'(frame_count), 32'd1);
      check_val("c1_err_count", 32'(err_count), 32'd0);
      check_val("c1_err_code", 32'(err_code), 32'd0);

      // Short line
      push_frame();
      push_err(3'd3);
      drive_frame(c_vl, c_vpw, 2, c_hp - 1, c_hpw, -1, -1);
      check_val("c2_unlocked", 32'(locked), 32'd0);
      check_val("c2_err_code", 32'(err_code), 32'd3);
      check_val("c2_err_count", 32'(err_count), 32'd1);
      good_frame();
      check_val("c2_relock_align", 32'(locked), 32'd0);
      good_frame();
      check_val("c2_relocked", 32'(locked), 32'd1);

      // Short hsync pulse
      push_frame();
      push_err(3'd4);
      drive_frame(c_vl, c_vpw, 1, c_hp, c_hpw - 1, -1, -1);
      check_val("c3_err_code", 32'(err_code), 32'd4);
      good_frame();
      good_frame();

      // Long vsync pulse
      push_frame();
      push_err(3'd2);
      drive_frame(c_vl, c_vpw + 1, -1, c_hp, c_hpw, -1, -1);
      check_val("c4_err_code", 32'(err_code), 32'd2);
      good_frame();
      good_frame();

      // Colour in blanking
      push_frame();
      push_err(3'd5);
      drive_frame(c_vl, c_vpw, -1, c_hp, c_hpw, 1, 1);
      check_val("c5_err_code", 32'(err_code), 32'd5);
      good_frame();
      good_frame();

      // Short frame whose closing vsync fall also carries colour: vlen wins
      push_frame();
      drive_frame(c_vl - 1, c_vpw, -1, c_hp, c_hpw, -1, -1);
      push_err(3'd1);
      drive_frame(c_vl, c_vpw, -1, c_hp, c_hpw, 0, 0);
      check_val("c6_err_code", 32'(err_code), 32'd1);
      check_val("c6_err_count", 32'(err_count), 32'd5);
      good_frame();
      good_frame();
      check_val("c6_relocked", 32'(locked), 32'd1);

      // Reset in the middle of a locked frame
      push_frame();
      drive_frame(3, c_vpw, -1, c_hp, c_hpw, -1, -1);
      check_val("c7_pre_locked", 32'(locked), 32'd1);
      @(negedge tb_dclk);
      #2;
      clr = 1'b1;
      #1;
      check_val("c7_locked", 32'(locked), 32'd0);
      check_val("c7_frame_done", 32'(frame_done), 32'd0);
      check_val("c7_frame_count", 32'(frame_count), 32'd0);
      check_val("c7_err_count", 32'(err_count), 32'd0);
      check_val("c7_err_code", 32'(err_code), 32'd0);
      @(negedge tb_dclk);
      @(posedge tb_dclk);
      #1;
      clr = 1'b0;
      exp_frames = 0;
      exp_errs   = 0;
      good_frame();
      check_val("c7_fresh_align", 32'(locked), 32'd0);
      good_frame();
      check_val("c7_fresh_locked", 32'(locked), 32'd1);

      // Error counter saturation, with a faster strobe to keep the run short
      pix_div = 1;
      for (int i = 0; i < 258; i++) begin
         push_frame();
         push_err(3'd4);
         drive_frame(3, c_vpw, 1, c_hp, c_hpw - 1, -1, -1);
         good_frame();
         good_frame();
      end
      check_val("c8_err_count_sat", 32'(err_count), 32'd255);
      check_val("c8_err_code", 32'(err_code), 32'd4);
      check_val("c8_frame_count", 32'(frame_count), 32'd258);
      check_val("c8_locked", 32'(locked), 32'd1);

      repeat (4) @(posedge tb_dclk);
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
